// File: rtl/getir_paket.sv
// Shared types and constants for the instruction fetch stage (getir_asamasi).
package getir_paket;

    typedef enum logic [1:0] {
        ILK   = 2'd0,
        CALIS = 2'd1,
        ATIK  = 2'd2
    } getir_durum_e;

    localparam logic [31:0] BUYRUK_BOYUT = 32'd4;

    typedef struct packed {
        logic [31:0] ps;
        logic [31:0] buyruk;
    } getir_girdi_t;

    function automatic logic [31:0] kelime_hizala(input logic [31:0] adres);
        return adres & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/getir_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage registers.
module getir_fifo #(
    parameter int DERINLIK = 2,
    parameter type veri_t = logic [31:0],
    localparam int SW = $clog2(DERINLIK + 1),
    localparam int PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          temizle_i,
    input  logic          itme_i,
    input  logic          cekme_i,
    input  veri_t         veri_i,
    output veri_t         veri_o,
    output logic          dolu_o,
    output logic          bos_o,
    output logic [SW-1:0] doluluk_o
);

    localparam logic [SW-1:0] DOLU_SAYI = SW'(DERINLIK);
    localparam logic [PW-1:0] SON_KONUM = PW'(DERINLIK - 1);

    veri_t         bellek_q [DERINLIK];
    logic [PW-1:0] bas_q, bas_d, kuyruk_q, kuyruk_d;
    logic [SW-1:0] sayi_q, sayi_d;
    logic          itme_s, cekme_s;

    function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
        return (p == SON_KONUM) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy next state; a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        cekme_s = cekme_i && !temizle_i && (sayi_q != '0);
        itme_s  = itme_i && !temizle_i && ((sayi_q != DOLU_SAYI) || cekme_s);
        if (temizle_i) begin
            bas_d    = '0;
            kuyruk_d = '0;
            sayi_d   = '0;
        end else begin
            bas_d    = cekme_s ? sonraki(bas_q) : bas_q;
            kuyruk_d = itme_s ? sonraki(kuyruk_q) : kuyruk_q;
            case ({itme_s, cekme_s})
                2'b10:   sayi_d = sayi_q + SW'(1);
                2'b01:   sayi_d = sayi_q - SW'(1);
                default: sayi_d = sayi_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bas_q    <= '0;
            kuyruk_q <= '0;
            sayi_q   <= '0;
            for (int i = 0; i < DERINLIK; i++) begin
                bellek_q[i] <= '0;
            end
        end else begin
            bas_q    <= bas_d;
            kuyruk_q <= kuyruk_d;
            sayi_q   <= sayi_d;
            if (itme_s) begin
                bellek_q[kuyruk_q] <= veri_i;
            end
        end
    end

    assign veri_o    = bellek_q[bas_q];
    assign dolu_o    = (sayi_q == DOLU_SAYI);
    assign bos_o     = (sayi_q == '0);
    assign doluluk_o = sayi_q;

endmodule

// File: rtl/getir_asamasi.sv
// Instruction fetch stage: owns PS, issues credit-limited memory requests, buffers words for decode.
// Optional GETIR_SAYAC_EN adds saturating discarded/delivered instruction counters.
module getir_asamasi
    import getir_paket::*;
#(
    parameter logic [31:0] BASLANGIC_PS    = 32'h0000_0000,
    parameter int          TAMPON_DERINLIK = 2,
    parameter int          MAKS_BEKLEYEN   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        getir_atla_i,
    input  logic [31:0] dallanma_hedef_i,
    output logic        bellek_istek_gecerli_o,
    output logic [31:0] bellek_istek_adres_o,
    input  logic        bellek_istek_hazir_i,
    input  logic        bellek_yanit_gecerli_i,
    input  logic [31:0] bellek_yanit_veri_i,
    output logic        buyruk_gecerli_o,
    output logic [31:0] buyruk_o,
    output logic [31:0] buyruk_ps_o,
    input  logic        coz_hazir_i
`ifdef GETIR_SAYAC_EN
    ,
    output logic [31:0] atilan_sayisi_o,
    output logic [31:0] getirilen_sayisi_o
`endif
);

    localparam int TW = $clog2(TAMPON_DERINLIK + 1);
    localparam int BW = $clog2(MAKS_BEKLEYEN + 1);

    getir_durum_e durum_q, durum_d;
    logic [31:0]  ps_q, ps_d;
    logic [BW-1:0] atik_q, atik_d;

    logic [BW-1:0] bekleyen_s;
    logic [TW-1:0] doluluk_s;
    logic          etiket_bos_s, etiket_dolu_s, buyruk_bos_s, buyruk_dolu_s;
    logic [31:0]   etiket_ps_s;
    getir_girdi_t  yeni_girdi_s, bas_girdi_s;
    logic          istek_gecerli_s, istek_kabul_s, yanit_s, atilacak_s;
    logic          buyruk_itme_s, buyruk_cekme_s;

    // Responses without a tag belong to requests from before a reset and are ignored.
    assign yanit_s         = bellek_yanit_gecerli_i && !etiket_bos_s;
    assign atilacak_s      = yanit_s && (getir_atla_i || (atik_q != '0));
    assign buyruk_itme_s   = yanit_s && !atilacak_s;
    assign buyruk_cekme_s  = !buyruk_bos_s && coz_hazir_i && !getir_atla_i;
    assign istek_gecerli_s = (durum_q != ILK) && !getir_atla_i && !buyruk_dolu_s && !etiket_dolu_s
                             && ((32'(bekleyen_s) + 32'(doluluk_s)) < 32'(TAMPON_DERINLIK));
    assign istek_kabul_s   = istek_gecerli_s && bellek_istek_hazir_i;
    assign yeni_girdi_s    = '{ps: etiket_ps_s, buyruk: bellek_yanit_veri_i};

    getir_fifo #(
        .DERINLIK (MAKS_BEKLEYEN),
        .veri_t   (logic [31:0])
    ) u_etiket_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .temizle_i (1'b0),
        .itme_i    (istek_kabul_s),
        .cekme_i   (yanit_s),
        .veri_i    (ps_q),
        .veri_o    (etiket_ps_s),
        .dolu_o    (etiket_dolu_s),
        .bos_o     (etiket_bos_s),
        .doluluk_o (bekleyen_s)
    );

    getir_fifo #(
        .DERINLIK (TAMPON_DERINLIK),
        .veri_t   (getir_girdi_t)
    ) u_buyruk_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .temizle_i (getir_atla_i),
        .itme_i    (buyruk_itme_s),
        .cekme_i   (buyruk_cekme_s),
        .veri_i    (yeni_girdi_s),
        .veri_o    (bas_girdi_s),
        .dolu_o    (buyruk_dolu_s),
        .bos_o     (buyruk_bos_s),
        .doluluk_o (doluluk_s)
    );

    // Next PS, discard counter and FSM state; a flush reloads the counter from the live outstanding count.
    always_comb begin
        if (getir_atla_i) begin
            ps_d   = kelime_hizala(dallanma_hedef_i);
            atik_d = bekleyen_s - (yanit_s ? BW'(1) : BW'(0));
        end else begin
            ps_d   = istek_kabul_s ? (ps_q + BUYRUK_BOYUT) : ps_q;
            atik_d = (yanit_s && (atik_q != '0)) ? (atik_q - BW'(1)) : atik_q;
        end
        case (durum_q)
            ILK:     durum_d = CALIS;
            CALIS:   durum_d = (getir_atla_i && (atik_d != '0)) ? ATIK : CALIS;
            ATIK:    durum_d = (atik_d == '0) ? CALIS : ATIK;
            default: durum_d = ILK;
        endcase
    end

    // Fetch state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q <= ILK;
            ps_q    <= BASLANGIC_PS;
            atik_q  <= '0;
        end else begin
            durum_q <= durum_d;
            ps_q    <= ps_d;
            atik_q  <= atik_d;
        end
    end

    assign bellek_istek_gecerli_o = istek_gecerli_s;
    assign bellek_istek_adres_o   = ps_q;
    assign buyruk_gecerli_o       = !buyruk_bos_s;
    assign buyruk_o               = bas_girdi_s.buyruk;
    assign buyruk_ps_o            = bas_girdi_s.ps;

`ifdef GETIR_SAYAC_EN
    logic [31:0] atilan_q, getirilen_q;

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            atilan_q    <= 32'd0;
            getirilen_q <= 32'd0;
        end else begin
            if (atilacak_s && (atilan_q != 32'hFFFF_FFFF)) begin
                atilan_q <= atilan_q + 32'd1;
            end
            if (buyruk_cekme_s && (getirilen_q != 32'hFFFF_FFFF)) begin
                getirilen_q <= getirilen_q + 32'd1;
            end
        end
    end

    assign atilan_sayisi_o    = atilan_q;
    assign getirilen_sayisi_o = getirilen_q;
`endif

endmodule

// File: tb/tb_getir_asamasi.sv
// Randomized bench for getir_asamasi against a queue-based memory and delivery model.
module tb_getir_asamasi;
    import getir_paket::*;

    logic        clk_i = 1'b0;
    logic        rst_i, getir_atla_i, bellek_istek_hazir_i, bellek_yanit_gecerli_i, coz_hazir_i;
    logic [31:0] dallanma_hedef_i, bellek_yanit_veri_i;
    logic        bellek_istek_gecerli_o, buyruk_gecerli_o;
    logic [31:0] bellek_istek_adres_o, buyruk_o, buyruk_ps_o;
`ifdef GETIR_SAYAC_EN
    logic [31:0] atilan_sayisi_o, getirilen_sayisi_o;
`endif

    always #5 clk_i = ~clk_i;

    getir_asamasi dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .getir_atla_i           (getir_atla_i),
        .dallanma_hedef_i       (dallanma_hedef_i),
        .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
        .bellek_istek_adres_o   (bellek_istek_adres_o),
        .bellek_istek_hazir_i   (bellek_istek_hazir_i),
        .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
        .bellek_yanit_veri_i    (bellek_yanit_veri_i),
        .buyruk_gecerli_o       (buyruk_gecerli_o),
        .buyruk_o               (buyruk_o),
        .buyruk_ps_o            (buyruk_ps_o),
        .coz_hazir_i            (coz_hazir_i)
`ifdef GETIR_SAYAC_EN
        ,
        .atilan_sayisi_o        (atilan_sayisi_o),
        .getirilen_sayisi_o     (getirilen_sayisi_o)
`endif
    );

    typedef struct {
        logic [31:0] adres;
        int          vade;
        int          donem;
    } istek_t;

    istek_t       mq[$];
    getir_girdi_t bq[$];

    int toplam = 0, hatali = 0;
    int cyc = 0, donem = 0, son_vade = 0;
    int gecikme = 1, rdy_yuzde = 0, coz_yuzde = 0;
    int atilan_m = 0, getirilen_m = 0, kabul_sayisi = 0;
    int ilk_istek = -1, ilk_gecerli = -1;
    bit atla_iste = 1'b0;
    logic [31:0] hedef_iste = 32'd0;
    logic [31:0] beklenen_ps = 32'd0;
    bit yak_adres_ac = 1'b0, yak_ps_ac = 1'b0;
    logic [31:0] yak_adres = 32'd0, yak_ps = 32'd0;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hatali++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", etiket, gozlenen, beklenen, cyc);
        end
    endtask

    function automatic logic [31:0] bellek_oku(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    // One clock: drive inputs after the edge, observe and update the model at the falling edge.
    task automatic adim();
        istek_t       r;
        getir_girdi_t g;
        int           vade;
        @(posedge clk_i);
        #1;
        cyc++;
        bellek_istek_hazir_i = ($urandom_range(99) < rdy_yuzde);
        coz_hazir_i          = ($urandom_range(99) < coz_yuzde);
        getir_atla_i         = atla_iste;
        dallanma_hedef_i     = hedef_iste;
        atla_iste            = 1'b0;
        if (mq.size() > 0 && mq[0].vade <= cyc) begin
            bellek_yanit_gecerli_i = 1'b1;
            bellek_yanit_veri_i    = bellek_oku(mq[0].adres);
        end else begin
            bellek_yanit_gecerli_i = 1'b0;
            bellek_yanit_veri_i    = $urandom;
        end
        @(negedge clk_i);

        if (buyruk_gecerli_o && ilk_gecerli < 0) ilk_gecerli = cyc;
        if (!getir_atla_i && buyruk_gecerli_o && coz_hazir_i) begin
            getirilen_m++;
            if (bq.size() == 0) begin
                kontrol("bayat_teslim", 32'(buyruk_gecerli_o), 32'd0);
            end else begin
                g = bq.pop_front();
                kontrol("buyruk", buyruk_o, g.buyruk);
                kontrol("buyruk_ps", buyruk_ps_o, g.ps);
            end
            if (yak_ps_ac) begin
                yak_ps    = buyruk_ps_o;
                yak_ps_ac = 1'b0;
            end
        end

        if (bellek_yanit_gecerli_i) begin
            r = mq.pop_front();
            if (getir_atla_i || r.donem != donem) atilan_m++;
            else bq.push_back('{ps: r.adres, buyruk: bellek_oku(r.adres)});
        end

        if (getir_atla_i) kontrol("atla_istek_yok", 32'(bellek_istek_gecerli_o), 32'd0);
        if (bellek_istek_gecerli_o && bellek_istek_hazir_i) begin
            kontrol("adres", bellek_istek_adres_o, beklenen_ps);
            beklenen_ps = beklenen_ps + 32'd4;
            vade = (cyc + gecikme > son_vade) ? cyc + gecikme : son_vade;
            son_vade = vade;
            mq.push_back('{adres: bellek_istek_adres_o, vade: vade, donem: donem});
            kontrol("bekleyen_sinir", 32'(mq.size() <= 2), 32'd1);
            kabul_sayisi++;
            if (ilk_istek < 0) ilk_istek = cyc;
            if (yak_adres_ac) begin
                yak_adres    = bellek_istek_adres_o;
                yak_adres_ac = 1'b0;
            end
        end

        if (getir_atla_i) begin
            bq.delete();
            donem++;
            beklenen_ps  = dallanma_hedef_i & ~32'h3;
            yak_adres_ac = 1'b1;
            yak_ps_ac    = 1'b1;
            yak_adres    = 32'hDEAD_BEEF;
            yak_ps       = 32'hDEAD_BEEF;
        end
    endtask

    task automatic bosalt();
        rdy_yuzde = 0;
        coz_yuzde = 100;
        repeat (14) adim();
        kontrol("bosalt_kuyruk", 32'(bq.size()), 32'd0);
        kontrol("bosalt_gecerli", 32'(buyruk_gecerli_o), 32'd0);
    endtask

    task automatic atla(input logic [31:0] hedef);
        atla_iste  = 1'b1;
        hedef_iste = hedef;
        adim();
    endtask

    initial begin
        int k0;
        logic [31:0] a0;
        rst_i = 1'b1;
        getir_atla_i = 1'b0;
        dallanma_hedef_i = 32'd0;
        bellek_istek_hazir_i = 1'b0;
        bellek_yanit_gecerli_i = 1'b0;
        bellek_yanit_veri_i = 32'd0;
        coz_hazir_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        kontrol("rst_istek", 32'(bellek_istek_gecerli_o), 32'd0);
        kontrol("rst_adres", bellek_istek_adres_o, 32'd0);
        kontrol("rst_gecerli", 32'(buyruk_gecerli_o), 32'd0);
        kontrol("rst_buyruk", buyruk_o, 32'd0);
        kontrol("rst_ps", buyruk_ps_o, 32'd0);
`ifdef GETIR_SAYAC_EN
        kontrol("rst_atilan", atilan_sayisi_o, 32'd0);
        kontrol("rst_getirilen", getirilen_sayisi_o, 32'd0);
`endif
        rst_i = 1'b0;
        bellek_istek_hazir_i = 1'b1;
        #1;
        kontrol("ilk_istek_yok", 32'(bellek_istek_gecerli_o), 32'd0);

        // Zero-wait memory, decode always ready.
        gecikme = 1; rdy_yuzde = 100; coz_yuzde = 100;
        repeat (20) adim();
        kontrol("ilk_gecikme", 32'(ilk_gecerli - ilk_istek), 32'd2);

        // Decode stall: only two credits exist.
        bosalt();
        rdy_yuzde = 100; coz_yuzde = 0;
        k0 = kabul_sayisi;
        repeat (10) adim();
        kontrol("durdurma_kabul", 32'(kabul_sayisi - k0), 32'd2);
        kontrol("durdurma_istek", 32'(bellek_istek_gecerli_o), 32'd0);
        coz_yuzde = 100;
        repeat (10) adim();
        bosalt();

        // Two late responses in flight, then redirect to 0x200.
        atla(32'h0000_0010);
        gecikme = 3; rdy_yuzde = 100; coz_yuzde = 100;
        k0 = kabul_sayisi;
        repeat (2) adim();
        kontrol("iki_bekleyen", 32'(kabul_sayisi - k0), 32'd2);
`ifdef GETIR_SAYAC_EN
        a0 = atilan_sayisi_o;
`else
        a0 = 32'd0;
`endif
        atla(32'h0000_0200);
        adim();
        kontrol("atik_durum", 32'(dut.durum_q), 32'(ATIK));
        gecikme = 1;
        repeat (12) adim();
        kontrol("atla_ps", yak_ps, 32'h0000_0200);
`ifdef GETIR_SAYAC_EN
        kontrol("atilan_iki", atilan_sayisi_o - a0, 32'd2);
`else
        kontrol("atilan_iki_yok", a0, 32'd0);
`endif
        bosalt();

        // Redirect coincident with a response, unaligned target.
        gecikme = 1; rdy_yuzde = 100;
        adim();
        atla(32'h0000_0103);
        repeat (6) adim();
        kontrol("hizali_adres", yak_adres, 32'h0000_0100);
        bosalt();

        // Second redirect while still discarding.
        gecikme = 3; rdy_yuzde = 100; coz_yuzde = 100;
        repeat (2) adim();
        atla(32'h0000_0300);
        atla(32'h0000_0400);
        gecikme = 1;
        repeat (15) adim();
        kontrol("cift_atla_ps", yak_ps, 32'h0000_0400);
        bosalt();

        // Wrap-around of the 32-bit PS.
        rdy_yuzde = 100; coz_yuzde = 100;
        atla(32'hFFFF_FFF8);
        repeat (12) adim();
        bosalt();

        // Randomized traffic with sporadic redirects.
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) begin
                gecikme   = $urandom_range(1, 4);
                rdy_yuzde = $urandom_range(30, 100);
                coz_yuzde = $urandom_range(20, 100);
            end
            if ($urandom_range(99) < 4) begin
                atla_iste  = 1'b1;
                hedef_iste = $urandom;
            end
            adim();
        end
        bosalt();
`ifdef GETIR_SAYAC_EN
        kontrol("atilan_sayac", atilan_sayisi_o, 32'(atilan_m));
        kontrol("getirilen_sayac", getirilen_sayisi_o, 32'(getirilen_m));
`endif
        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule
